// File: rtl/adc_pkg.sv
// Shared constants and types for the MCP3008 scanning reader.
package adc_pkg;

    localparam int ADC_BITS     = 10;
    localparam int CMD_BITS     = 5;
    localparam int FRAME_SCLKS  = 17;
    localparam int FRAME_HALVES = 2 * FRAME_SCLKS;

    typedef logic [ADC_BITS-1:0] adc_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_GAP
    } adc_state_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick for SCLK: one-cycle pulse every CLK_DIV clocks while enabled.
module spi_tick_gen #(
    parameter int CLK_DIV = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    logic [7:0] cnt;

    assign tick = en && (cnt == 8'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mcp3008_reader.sv
// Continuous round-robin reader for an MCP3008 ADC over SPI mode 0,0.
// Each frame: SETUP (1 half), SHIFT (34 halves), GAP (2 halves) = 37*CLK_DIV clocks.
module mcp3008_reader
    import adc_pkg::*;
#(
    parameter int CLK_DIV  = 6,
    parameter int CHANNELS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ena,
    output logic                      adc_sclk,
    output logic                      adc_csn,
    output logic                      adc_mosi,
    input  logic                      adc_miso,
    output adc_word_t [CHANNELS-1:0]  data,
    output logic                      valid,
    output logic [2:0]                ch,
    output logic                      sweep_done,
    output logic                      busy
);

    localparam logic [5:0] LAST_HALF = 6'(FRAME_HALVES - 1);
    // Rising edge k is entered from half 2k-3; result bits sit on edges 8..17.
    localparam logic [5:0] SAMPLE_LO = 6'(2 * (FRAME_SCLKS - ADC_BITS + 1) - 3);
    localparam logic [5:0] SAMPLE_HI = 6'(2 * FRAME_SCLKS - 3);
    localparam logic [2:0] LAST_CH   = 3'(CHANNELS - 1);

    adc_state_t            state;
    adc_state_t            state_nx;
    logic                  tick;
    logic [5:0]            half_cnt;
    logic                  gap_cnt;
    adc_word_t             shreg;
    logic [5:0]            bit_idx;
    logic [2:0]            cmd_sel;
    logic [CMD_BITS-1:0]   cmd;
    logic                  frame_end;
    logic                  gap_end;
    logic                  sample_now;

    spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state != ST_IDLE),
        .tick (tick)
    );

    assign frame_end  = tick && (state == ST_SHIFT) && (half_cnt == LAST_HALF);
    assign gap_end    = tick && (state == ST_GAP) && gap_cnt;
    assign sample_now = tick && (state == ST_SHIFT) && half_cnt[0]
                        && (half_cnt >= SAMPLE_LO) && (half_cnt <= SAMPLE_HI);

    // Command bit index advances on each falling edge (odd half boundaries).
    assign bit_idx = (half_cnt + 6'd1) >> 1;
    assign cmd_sel = 3'(CMD_BITS - 1) - bit_idx[2:0];
    assign cmd     = {2'b11, ch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (ena)       state_nx = ST_SETUP;
            ST_SETUP: if (tick)      state_nx = ST_SHIFT;
            ST_SHIFT: if (frame_end) state_nx = ST_GAP;
            ST_GAP:   if (gap_end)   state_nx = ena ? ST_SETUP : ST_IDLE;
            default:                 state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        adc_csn  = 1'b1;
        adc_sclk = 1'b0;
        adc_mosi = 1'b0;
        busy     = 1'b0;
        case (state)
            ST_SETUP: begin
                adc_csn  = 1'b0;
                adc_mosi = 1'b1;
                busy     = 1'b1;
            end
            ST_SHIFT: begin
                adc_csn  = 1'b0;
                adc_sclk = ~half_cnt[0];
                adc_mosi = (bit_idx < 6'(CMD_BITS)) ? cmd[cmd_sel] : 1'b0;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            half_cnt <= '0;
            gap_cnt  <= 1'b0;
            ch       <= '0;
        end else begin
            if (state != ST_SHIFT) begin
                half_cnt <= '0;
            end else if (tick) begin
                half_cnt <= frame_end ? 6'd0 : half_cnt + 6'd1;
            end
            if (state != ST_GAP) begin
                gap_cnt <= 1'b0;
            end else if (tick) begin
                gap_cnt <= ~gap_cnt;
            end
            if (gap_end) begin
                ch <= (ch == LAST_CH) ? 3'd0 : ch + 3'd1;
            end
        end
    end

    // Result capture: shift register is only published at frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            data       <= '0;
            valid      <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            valid      <= frame_end;
            sweep_done <= frame_end && (ch == LAST_CH);
            if (sample_now) begin
                shreg <= {shreg[ADC_BITS-2:0], adc_miso};
            end
            for (int k = 0; k < CHANNELS; k++) begin
                if (frame_end && (ch == 3'(k))) begin
                    data[k] <= shreg;
                end
            end
        end
    end

endmodule

// File: doc/mcp3008_reader.md
MCP3008_READER -- requirements
Module: mcp3008_reader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 6, meaning clk cycles per SCLK half-period (range 2..255).
REQ-002 SHALL have parameter CHANNELS, default 8, meaning the number of single-ended channels scanned (range 1..8).
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port ena, input, 1 bit: continuous-scan enable.
REQ-006 SHALL have port adc_sclk, output, 1 bit: SPI clock, mode 0,0.
REQ-007 SHALL have port adc_csn, output, 1 bit: active-low chip select.
REQ-008 SHALL have port adc_mosi, output, 1 bit: command bits to the ADC.
REQ-009 SHALL have port adc_miso, input, 1 bit: result bits from the ADC.
REQ-010 SHALL have port data, output, CHANNELS x 10 bits: last result of each channel.
REQ-011 SHALL have port valid, output, 1 bit: 1-cycle strobe on each data update.
REQ-012 SHALL have port ch, output, 3 bits: channel index of the current or last conversion.
REQ-013 SHALL have port sweep_done, output, 1 bit: 1-cycle strobe after the last channel completes.
REQ-014 SHALL have port busy, output, 1 bit: high while csn is low.

Function
REQ-015 SHALL implement FSM IDLE -> SETUP -> SHIFT -> GAP -> (SETUP or IDLE).
REQ-016 IDLE: csn=1, sclk=0, mosi=0; SHALL leave IDLE on the first clk with ena=1.
REQ-017 SETUP: csn=0, sclk=0, mosi=start bit 1; SHALL last CLK_DIV cycles.
REQ-018 SHIFT: SHALL run 17 SCLK periods (34 half-periods of CLK_DIV cycles each); sclk SHALL start high.
REQ-019 mosi SHALL change only on falling sclk edges, in the order start=1, SGL=1, D2, D1, D0 = ch[2:0], then 0 for the rest of the conversion.
REQ-020 SHALL sample adc_miso on clk cycles where sclk rises, at rising edges 8..17 (B9 first, MSB-first into a 10-bit shift register); edges 1..7 SHALL be ignored (null bit included).
REQ-021 After the 17th falling edge: csn=1, data[ch] updated, valid=1 for one cycle in the same cycle.
REQ-022 GAP: csn=1, sclk=0; SHALL last 2*CLK_DIV cycles; at exit ch SHALL increment, wrapping CHANNELS-1 -> 0.
REQ-023 sweep_done SHALL pulse together with valid when ch = CHANNELS-1.
REQ-024 Conversion period SHALL be exactly 37*CLK_DIV cycles (222 at default).
REQ-025 ena is sampled only at GAP exit: ena=0 -> IDLE with ch kept; a conversion in progress is never truncated.
REQ-026 data SHALL never hold a partial result; the shift register is only copied at REQ-021.
REQ-027 ena rising in the cycle GAP exits SHALL have the same effect as ena held high.

Reset
REQ-028 While rst=1: state=IDLE, csn=1, sclk=0, mosi=0, ch=0, all data=0, valid=0, sweep_done=0, busy=0, counters=0.
REQ-029 rst mid-conversion SHALL raise csn on the next clk edge and discard the partial result.
REQ-030 After rst falls, the first conversion SHALL be channel 0.

Structure
REQ-031 SHALL place ADC_BITS=10, CMD_BITS=5, FRAME_SCLKS=17, the state enum, and typedef adc_word_t in shared package adc_pkg.
REQ-032 SHALL contain one sub-module, spi_tick_gen, which produces the half-period tick from CLK_DIV; everything else SHALL stay flat.

Verification
REQ-033 MCP3008 model loaded with ch0..7 = 1..8, ena=1 for one sweep: data[k] = k+1, 8 valid pulses 222 cycles apart, sweep_done with ch=7.
REQ-034 Monitor mosi per frame: bits 1,1,ch[2],ch[1],ch[0], then 0; mosi stable while sclk high; csn high for at least 12 cycles between frames.
REQ-035 Model ch0 = 10'h3FF then 10'h000: data[0] follows exactly, with no bit slip (10'h2AA also checked).
REQ-036 Drop ena mid-frame on ch3: frame completes, data[3] updated, FSM reaches IDLE; re-enable: next frame is ch4.
REQ-037 Assert rst at SHIFT half-period 20: csn=1 one cycle later, all data=0, the next frame after release uses ch0.
REQ-038 CLK_DIV=2, CHANNELS=3: period 74 cycles, ch wraps 2->0, sweep_done every third valid.
